// File: rtl/hex_readout.sv
// hex_readout: renders DIGITS hex characters as 3x5-cell block glyphs at a fixed
// screen position. Datapath writes are double-buffered (shadow -> disp) and only
// take effect at frame_start so a readout never tears. Two-stage pixel pipeline.
// Optional feature: define HEX_READOUT_LZB_EN to blank leading zero digits.
module hex_readout #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned X_ORIGIN = 400,
  parameter int unsigned Y_ORIGIN = 171,
  parameter int unsigned SEG      = 20,
  parameter int unsigned GAP      = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  frame_start,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  output logic                  hit,
  output logic                  applied
);

  localparam int unsigned Pitch = 3 * SEG + GAP;

  logic [4*DIGITS-1:0] shadow, disp;
  logic                pending;

  // Stage-1 registers
  logic                s1_in, s1_blank;
  logic [3:0]          s1_nib;
  logic [2:0]          s1_row;
  logic [1:0]          s1_col;

  // Stage-1 next values
  logic [10:0]         dx, dy;
  logic [31:0]         dxw, dyw;
  logic                in_reg, sel_blank;
  logic [3:0]          sel_nib;
  logic [2:0]          row;
  logic [1:0]          col;
  logic [DIGITS-1:0]   lz;

  // Shadow/display double buffer; a same-cycle load+frame_start bypasses the shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      applied <= 1'b0;
    end else begin
      applied <= 1'b0;
      if (load && frame_start) begin
        shadow  <= value;
        disp    <= value;
        pending <= 1'b0;
        applied <= 1'b1;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (frame_start && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
        applied <= 1'b1;
      end
    end
  end

  // Leading-zero mask, derived from the displayed value
`ifdef HEX_READOUT_LZB_EN
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz       = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      zero_run = zero_run && (disp[4*(int'(DIGITS)-1-k) +: 4] == 4'h0);
      lz[k]    = zero_run && (k < int'(DIGITS) - 1);
    end
  end
`else
  always_comb lz = '0;
`endif

  // Locate the pixel: digit by pitch window, cell by constant SEG multiples
  always_comb begin
    dx        = {1'b0, hcount} - 11'(X_ORIGIN);
    dy        = {1'b0, vcount} - 11'(Y_ORIGIN);
    dxw       = 32'(dx);
    dyw       = 32'(dy);
    in_reg    = 1'b0;
    sel_blank = 1'b0;
    sel_nib   = 4'h0;
    col       = 2'd0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (dxw >= 32'(k) * Pitch && dxw < 32'(k) * Pitch + 3 * SEG) begin
        in_reg    = 1'b1;
        sel_nib   = disp[4*(int'(DIGITS)-1-k) +: 4];
        sel_blank = lz[k];
        if (dxw < 32'(k) * Pitch + SEG)          col = 2'd0;
        else if (dxw < 32'(k) * Pitch + 2 * SEG) col = 2'd1;
        else                                     col = 2'd2;
      end
    end
    if (32'(hcount) < X_ORIGIN || 32'(vcount) < Y_ORIGIN || dyw >= 5 * SEG) in_reg = 1'b0;
    if (dyw < SEG)          row = 3'd0;
    else if (dyw < 2 * SEG) row = 3'd1;
    else if (dyw < 3 * SEG) row = 3'd2;
    else if (dyw < 4 * SEG) row = 3'd3;
    else                    row = 3'd4;
  end

  // Stage 1: latch region, nibble, blank and cell coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_in    <= 1'b0;
      s1_blank <= 1'b0;
      s1_nib   <= 4'h0;
      s1_row   <= 3'd0;
      s1_col   <= 2'd0;
    end else begin
      s1_in    <= in_reg;
      s1_blank <= sel_blank;
      s1_nib   <= sel_nib;
      s1_row   <= row;
      s1_col   <= col;
    end
  end

  // Glyph ROM: five 3-bit rows, top row in [14:12], leftmost column is the MSB
  function automatic logic [14:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 15'b111_101_101_101_111;
      4'h1:    glyph = 15'b001_001_001_001_001;
      4'h2:    glyph = 15'b111_001_111_100_111;
      4'h3:    glyph = 15'b111_001_111_001_111;
      4'h4:    glyph = 15'b101_101_111_001_001;
      4'h5:    glyph = 15'b111_100_111_001_111;
      4'h6:    glyph = 15'b111_100_111_101_111;
      4'h7:    glyph = 15'b111_001_001_001_001;
      4'h8:    glyph = 15'b111_101_111_101_111;
      4'h9:    glyph = 15'b111_101_111_001_111;
      4'hA:    glyph = 15'b111_101_111_101_101;
      4'hB:    glyph = 15'b100_100_111_101_111;
      4'hC:    glyph = 15'b111_100_100_100_111;
      4'hD:    glyph = 15'b001_001_111_101_111;
      4'hE:    glyph = 15'b111_100_111_100_111;
      default: glyph = 15'b111_100_111_100_100;
    endcase
  endfunction

  logic [14:0] g;
  logic [2:0]  row_bits;
  logic        lit;

  // Glyph lookup for the stage-1 cell
  always_comb begin
    g = glyph(s1_nib);
    case (s1_row)
      3'd0:    row_bits = g[14:12];
      3'd1:    row_bits = g[11:9];
      3'd2:    row_bits = g[8:6];
      3'd3:    row_bits = g[5:3];
      default: row_bits = g[2:0];
    endcase
    lit = row_bits[2'd2 - s1_col];
  end

  // Stage 2: registered hit
  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= s1_in & ~s1_blank & lit;
  end

endmodule

// File: doc/hex_readout.md
# hex_readout

Parametrised multi-digit hexadecimal readout renderer for the VGA datapath display. It draws `DIGITS` hex characters as 3x5-cell block glyphs at a fixed screen position and raises `hit` for every pixel that belongs to a lit cell. Writes from the datapath are double-buffered and applied only at frame boundaries, so a readout never tears mid-frame. The pixel path is a 2-stage pipeline that feeds the colour mux.

## Interface
- `DIGITS`, 4: number of hex digits; digit 0 is the most significant and the leftmost.
- `X_ORIGIN`, 400: left pixel column of digit 0.
- `Y_ORIGIN`, 171: top pixel row of all digits.
- `SEG`, 20: cell size in pixels; a glyph is 3·SEG wide and 5·SEG tall.
- `GAP`, 20: blank columns between adjacent glyphs; digit pitch is 3·SEG+GAP.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `value` in 4·DIGITS: new readout value; nibble [4·DIGITS-1:4·DIGITS-4] is digit 0.
- `load` in 1: captures `value` into the shadow register.
- `frame_start` in 1: one-cycle pulse at start of frame; applies a pending shadow.
- `hcount` in 10: current pixel column.
- `vcount` in 10: current pixel row.
- `hit` out 1: registered; pixel lies in a lit cell.
- `applied` out 1: registered one-cycle pulse; the display register was updated.

## Operation
- Registers: `shadow`, `pending`, `disp` (4·DIGITS each except pending), plus stage-1 pipeline registers.
- Load/apply behaviour:
  - `load` sets shadow←value and pending←1.
  - `frame_start` with pending=1 sets disp←shadow, pending←0 and applied←1.
  - `frame_start` with pending=0 causes no change.
  - `load` and `frame_start` in the same cycle: disp←value directly, pending←0, applied←1.
  - Repeated `load` before a frame_start: the last value wins.
- Stage 1 (registered):
  - dx = hcount − X_ORIGIN and dy = vcount − Y_ORIGIN, computed in 11 bits.
  - The pixel is out of region if hcount<X_ORIGIN, vcount<Y_ORIGIN, or dy≥5·SEG.
  - Digit k is selected if k·pitch ≤ dx < k·pitch+3·SEG. Pixels in a gap or past the last digit are out of region.
  - Cell column c∈0..2 and cell row r∈0..4 are found by comparison against constant multiples of SEG. No dividers.
  - The selected nibble and blank flag are latched.
- Stage 2 (registered): `hit` = in_region & ~blank & glyph[nibble][r][c].
- Glyph ROM rows, top to bottom, with bits giving columns left to right:
  - 0 111/101/101/101/101→111 (rows: 111,101,101,101,111)
  - 1 001 ×5
  - 2 111,001,111,100,111
  - 3 111,001,111,001,111
  - 4 101,101,111,001,001
  - 5 111,100,111,001,111
  - 6 111,100,111,101,111
  - 7 111,001,001,001,001
  - 8 111,101,111,101,111
  - 9 111,101,111,001,111
  - A 111,101,111,101,101
  - b 100,100,111,101,111
  - C 111,100,100,100,111
  - d 001,001,111,101,111
  - E 111,100,111,100,111
  - F 111,100,111,100,100

## Timing
- Reset values: hit=0, applied=0, disp=0, shadow=0, pending=0, all stage-1 registers 0.
- `rst` has priority over load and frame_start in the same cycle.
- Reset mid-operation discards any pending shadow.
- Pixel latency is 2 cycles: `hit` at edge N+2 reflects hcount/vcount sampled at edge N and the `disp` value held before edge N+1.
- `applied` rises at the edge following the frame_start cycle and is high for exactly 1 cycle.
- A new `disp` affects `hit` from 2 cycles after the update edge onward.
- Throughput is one pixel per clock with no stalls.
- hcount/vcount need not be in-order; each cycle is independent.

## Configuration
- `HEX_READOUT_LZB_EN` defined: leading-zero blanking is enabled.
  - Digits 0..DIGITS-2 that are zero, and have only zero digits to their left, set blank=1 and render nothing.
  - The least significant digit is never blanked.
  - Blanking is evaluated from `disp`.
- Undefined: blank is tied to 0 and every digit is rendered, including leading zeros.

## Test plan
Defaults throughout: digit x ranges are 400–459, 480–539, 560–619 and 640–699; y range is 171–270.
- **Reset state:** after reset, drive (410,180). Expect hit=1 two cycles later. Drive (420,220), the centre of a '0'. Expect hit=0.
- **Deferred apply:** load 0x1234 without frame_start. Expect (400,171) still hit=1, since disp is still 0. Pulse frame_start. Expect applied=1 for one cycle, then (400,171)→0 and (440,171)→1.
- **Simultaneous load and frame_start:** value 0xABCD. Expect applied on the next cycle. Then (640,171)→0 and (680,171)→1 (digit 'd'). Also (560,171)→1 and (580,200)→0 (digit 'C').
- **Boundaries, disp=0:**
  - (459,171)→1, (460,171)→0, (479,171)→0, (480,171)→1.
  - (399,171)→0, (400,270)→1, (400,271)→0, (700,171)→0.
- **Leading-zero blanking, disp=0x00F0:**
  - With the macro: (400,171)→0, (480,171)→0, (560,171)→1, (640,171)→1.
  - Without the macro: (400,171)→1.
  - disp=0x0000 with the macro: only digit 3 is lit.
- **Reset mid-operation:** load 0x5555, assert rst for one cycle, then pulse frame_start. Expect applied=0, disp stays 0, and (410,180)→1.
